// File: rtl/video_mode_pkg.sv
// Shared types and constants for the video mode change sequencer.
package video_mode_pkg;

  localparam int unsigned VMODE_W = 4;
  localparam int unsigned FC_W    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WD_W    = 23;

  typedef enum logic [2:0] {
    IDLE,
    FAST,
    WAIT_VS,
    MUTE,
    SETTLE
  } vm_state_t;

  typedef struct packed {
    logic       sd;
    logic [1:0] sl;
    logic       hq2x;
  } vmode_t;

  // True when two modes differ at most in the scanline level (no timing change).
  function automatic logic only_sl_diff(input vmode_t a, input vmode_t b);
    return (a.sd == b.sd) && (a.hq2x == b.hq2x);
  endfunction

endpackage

// File: rtl/video_mode_ctrl_vsync_frame_tick.sv
// Frame tick generator: vsync falling-edge detect, plus an optional watchdog
// that fakes a tick when video is stopped.
// Optional feature macro: VIDEO_MODE_CTRL_WATCHDOG_EN
module vsync_frame_tick
  import video_mode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vs_in,
  input  logic run,
  output logic tick_c
);

  logic vs_d;
  logic vs_fall;

  // Delay vsync by one clock for edge detection.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) vs_d <= 1'b0;
    else          vs_d <= vs_in;
  end

  assign vs_fall = vs_d & ~vs_in;

`ifdef VIDEO_MODE_CTRL_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  assign wd_hit = run && (wd_cnt == WD_LAST);

  // Watchdog counts only while a sequence is pending; any real or fake tick restarts it.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                      wd_cnt <= '0;
    else if (!run || vs_fall || wd_hit) wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign tick_c = vs_fall | wd_hit;
`else
  logic unused_wd;
  assign unused_wd = ^{run, 32'(TIMEOUT_CYCLES)};
  assign tick_c    = vs_fall;
`endif

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode change sequencer: debounces mode requests and applies them at
// frame boundaries, muting the mixer around timing-altering changes.
// Optional feature macro: VIDEO_MODE_CTRL_WATCHDOG_EN (vsync-loss watchdog).
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int unsigned MUTE_FRAMES    = 2,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             vs_in,
  input  logic             scandoubler_req,
  input  logic [1:0]       scanlines_req,
  input  logic             hq2x_req,
  output logic             scandoubler,
  output logic [1:0]       scanlines,
  output logic             hq2x,
  output logic             mute,
  output logic             busy,
  output logic [CNT_W-1:0] change_cnt
);

  localparam int unsigned     STAB_W      = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [FC_W-1:0] MUTE_LAST   = FC_W'(MUTE_FRAMES - 1);
  localparam logic [FC_W-1:0] SETTLE_LAST = FC_W'(SETTLE_FRAMES - 1);

  vm_state_t         state, state_nx;
  vmode_t            req, req_d, cur, cur_nx, pend, pend_nx;
  logic [STAB_W-1:0] stab_cnt;
  logic              stable;
  logic [FC_W-1:0]   fc, fc_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              mute_nx, busy_nx;
  logic              tick_c;

  assign req    = '{sd: scandoubler_req, sl: scanlines_req, hq2x: hq2x_req};
  assign stable = (stab_cnt == STAB_MAX);

  vsync_frame_tick #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tick (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .vs_in  (vs_in),
    .run    (state != IDLE),
    .tick_c (tick_c)
  );

  // Request stability counter: restarts on any request change, saturates when stable.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      req_d    <= '0;
      stab_cnt <= '0;
    end else begin
      req_d <= req;
      if (req != req_d) stab_cnt <= '0;
      else if (!stable) stab_cnt <= stab_cnt + STAB_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur        <= '0;
      pend       <= '0;
      fc         <= '0;
      mute       <= 1'b0;
      busy       <= 1'b0;
      change_cnt <= '0;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      pend       <= pend_nx;
      fc         <= fc_nx;
      mute       <= mute_nx;
      busy       <= busy_nx;
      change_cnt <= cnt_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    pend_nx  = pend;
    fc_nx    = fc;
    mute_nx  = mute;
    cnt_nx   = change_cnt;
    case (state)
      IDLE: begin
        if (stable && (req != cur)) begin
          pend_nx  = req;
          state_nx = only_sl_diff(req, cur) ? FAST : WAIT_VS;
        end
      end
      FAST: begin
        if (tick_c) begin
          cur_nx.sl = pend.sl;
          cnt_nx    = change_cnt + CNT_W'(1);
          state_nx  = IDLE;
        end
      end
      WAIT_VS: begin
        if (stable && (req == cur)) begin
          state_nx = IDLE;
        end else begin
          if (stable && (req != pend)) pend_nx = req;
          if (tick_c) begin
            mute_nx  = 1'b1;
            fc_nx    = '0;
            state_nx = MUTE;
          end
        end
      end
      MUTE: begin
        if (tick_c) begin
          if (fc == MUTE_LAST) begin
            cur_nx   = pend;
            cnt_nx   = change_cnt + CNT_W'(1);
            fc_nx    = '0;
            state_nx = SETTLE;
          end else begin
            fc_nx = fc + FC_W'(1);
          end
        end
      end
      SETTLE: begin
        if (tick_c) begin
          if (fc == SETTLE_LAST) begin
            mute_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            fc_nx = fc + FC_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  assign scandoubler = cur.sd;
  assign scanlines   = cur.sl;
  assign hq2x        = cur.hq2x;

endmodule
